// File: rtl/uart_pkg.sv
// Shared definitions for the hex UART transmitter.
//   - hex_state_e : top sequencer states (CR/LF only with UART_HEX_TX_CRLF_EN)
//   - ASCII_*     : character constants used by the sequencer
//   - FRAME_BITS  : bits in one 8N1 frame (start + 8 data + stop)
//   - nib_to_ascii: 4-bit nibble to uppercase ASCII hex digit
package uart_pkg;

    localparam int FRAME_BITS = 10;

    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_A  = 8'h41;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HI   = 3'd1,
        LO   = 3'd2
`ifdef UART_HEX_TX_CRLF_EN
        ,
        CR   = 3'd3,
        LF   = 3'd4
`endif
    } hex_state_e;

    function automatic logic [7:0] nib_to_ascii(input logic [3:0] nib);
        if (nib <= 4'd9)
            return ASCII_0 + {4'h0, nib};
        else
            return ASCII_A + ({4'h0, nib} - 8'd10);
    endfunction

endpackage

// File: rtl/uart_hex_tx_if.sv
// Byte handshake between a sender and uart_hex_tx.
//   byte_valid : sender has a byte on byte_data (held until accepted)
//   byte_data  : byte to be printed as two hex characters
//   byte_ready : transmitter can take a byte this cycle
// master = byte sender, slave = uart_hex_tx.
interface uart_hex_tx_if;

    logic       byte_valid;
    logic [7:0] byte_data;
    logic       byte_ready;

    modport master (
        output byte_valid,
        output byte_data,
        input  byte_ready
    );

    modport slave (
        input  byte_valid,
        input  byte_data,
        output byte_ready
    );

endinterface

// File: rtl/uart_bit_tx.sv
// 8N1 serializer: loads {stop, char, start} and shifts it out LSB first,
// holding each bit for BIT_CNT_MAX clocks.
//   sys_clk, sys_rst : clock, synchronous active-high reset
//   load             : capture char and start a frame (allowed in the last
//                      cycle of a running frame, giving back-to-back frames)
//   char             : character to send
//   txd              : registered serial line, idle high
//   busy             : frame in progress
//   done             : one-cycle pulse as the stop bit ends; it fires one
//                      clock before the stop bit's final cycle so the caller
//                      can register its next action and still meet the
//                      boundary with no idle gap
// BIT_CNT_MAX must be at least 2.
module uart_bit_tx
#(
    parameter int BIT_CNT_MAX = 868
)
(
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       load,
    input  logic [7:0] char,
    output logic       txd,
    output logic       busy,
    output logic       done
);
    import uart_pkg::*;

    localparam int                CNT_W    = (BIT_CNT_MAX > 1) ? $clog2(BIT_CNT_MAX) : 1;
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(BIT_CNT_MAX - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [3:0]        IDX_LAST = 4'(FRAME_BITS - 1);

    logic [FRAME_BITS-1:0] frame_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [3:0]            idx_q;

    // cnt_q counts down within a bit; terminal count 0 ends the bit.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            frame_q <= '1;
            cnt_q   <= '0;
            idx_q   <= '0;
            busy    <= 1'b0;
            txd     <= 1'b1;
        end else if (load) begin
            frame_q <= {1'b1, char, 1'b0};
            cnt_q   <= CNT_LOAD;
            idx_q   <= '0;
            busy    <= 1'b1;
            txd     <= 1'b0;
        end else if (busy) begin
            if (cnt_q == '0) begin
                if (idx_q == IDX_LAST) begin
                    busy <= 1'b0;
                    txd  <= 1'b1;
                end else begin
                    idx_q   <= idx_q + 4'd1;
                    cnt_q   <= CNT_LOAD;
                    frame_q <= {1'b1, frame_q[FRAME_BITS-1:1]};
                    txd     <= frame_q[1];
                end
            end else begin
                cnt_q <= cnt_q - CNT_ONE;
            end
        end
    end

    assign done = busy && (idx_q == IDX_LAST) && (cnt_q == CNT_ONE);

endmodule

// File: rtl/uart_hex_tx.sv
// Hex UART transmitter: each accepted byte is sent as two uppercase ASCII
// hex characters (high nibble first), each as an 8N1 frame, back to back.
// Optional feature macro: UART_HEX_TX_CRLF_EN appends CR and LF per byte.
//   sys_clk, sys_rst : clock, synchronous active-high reset
//   byte_if (slave)  : byte_valid / byte_data in, byte_ready out
//   uart_txd         : serial line, idle high, driven from a flop
//   tx_busy          : a character frame of the current byte is in progress
//
// state | meaning
// IDLE  | waiting for a byte; byte_ready high
// HI    | sending the high-nibble character
// LO    | sending the low-nibble character
// CR    | sending carriage return (CRLF build only)
// LF    | sending line feed (CRLF build only)
module uart_hex_tx
#(
    parameter int BPS         = 57600,
    parameter int SYS_CLK_FRE = 50_000_000
)
(
    input  logic          sys_clk,
    input  logic          sys_rst,
    uart_hex_tx_if.slave  byte_if,
    output logic          uart_txd,
    output logic          tx_busy
);
    import uart_pkg::*;

    localparam int BIT_CNT_MAX = SYS_CLK_FRE / BPS;

    hex_state_e state_q, state_d;
    logic [7:0] data_q;
    logic       reload_q, reload_d;
    logic       accept;
    logic       load;
    logic [7:0] char_c;
    logic       bit_busy;
    logic       bit_done;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q  <= IDLE;
            data_q   <= '0;
            reload_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            reload_q <= reload_d;
            if (accept)
                data_q <= byte_if.byte_data;
        end
    end

    // The serializer's done arrives one cycle before a frame ends. Moving
    // state there puts IDLE (ready) in the final stop cycle so a new byte
    // lands on the frame boundary; between characters, reload_q issues the
    // next load exactly on that boundary.
    always_comb begin
        state_d  = state_q;
        reload_d = 1'b0;
        accept   = 1'b0;
        char_c   = ASCII_0;
        case (state_q)
            IDLE: begin
                char_c = nib_to_ascii(byte_if.byte_data[7:4]);
                if (byte_if.byte_valid) begin
                    accept  = 1'b1;
                    state_d = HI;
                end
            end
            HI: begin
                char_c = nib_to_ascii(data_q[7:4]);
                if (bit_done) begin
                    state_d  = LO;
                    reload_d = 1'b1;
                end
            end
            LO: begin
                char_c = nib_to_ascii(data_q[3:0]);
                if (bit_done) begin
`ifdef UART_HEX_TX_CRLF_EN
                    state_d  = CR;
                    reload_d = 1'b1;
`else
                    state_d  = IDLE;
`endif
                end
            end
`ifdef UART_HEX_TX_CRLF_EN
            CR: begin
                char_c = ASCII_CR;
                if (bit_done) begin
                    state_d  = LF;
                    reload_d = 1'b1;
                end
            end
            LF: begin
                char_c = ASCII_LF;
                if (bit_done)
                    state_d = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    assign load               = accept || reload_q;
    assign byte_if.byte_ready = (state_q == IDLE);
    assign tx_busy            = bit_busy && (state_q != IDLE);

    uart_bit_tx #(
        .BIT_CNT_MAX (BIT_CNT_MAX)
    ) u_bit_tx (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .load    (load),
        .char    (char_c),
        .txd     (uart_txd),
        .busy    (bit_busy),
        .done    (bit_done)
    );

endmodule

// File: tb/tb_uart_hex_tx.sv
// Bench for uart_hex_tx at 1 MHz / 100 kbaud (10 clocks per bit).
// Expected line levels come from a reference model: the byte is turned into
// its hex text (plus CR LF in the CRLF build) and each character is drawn
// as a 10-slot 8N1 waveform, every slot BIT_CYC samples wide.
module tb_uart_hex_tx;

    localparam int SYS_CLK_FRE = 1_000_000;
    localparam int BPS         = 100_000;
    localparam int BIT_CYC     = SYS_CLK_FRE / BPS;
    localparam int FRAME_CYC   = 10 * BIT_CYC;
`ifdef UART_HEX_TX_CRLF_EN
    localparam int CHARS       = 4;
`else
    localparam int CHARS       = 2;
`endif
    localparam int BYTE_CYC    = CHARS * FRAME_CYC;
    localparam int LIMIT       = 4 * BYTE_CYC;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    logic uart_txd;
    logic tx_busy;

    uart_hex_tx_if bif();

    uart_hex_tx #(
        .BPS         (BPS),
        .SYS_CLK_FRE (SYS_CLK_FRE)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .byte_if  (bif.slave),
        .uart_txd (uart_txd),
        .tx_busy  (tx_busy)
    );

    always #5 sys_clk = ~sys_clk;

    int n_checks = 0;
    int n_pass   = 0;

    string      hex_digits = "0123456789ABCDEF";
    logic [7:0] exp_chars[$];
    logic       exp_line[$];
    logic       got_line[$];
    logic       got_ready[$];
    logic       got_busy[$];

    // ---------------- reference model ----------------
    task automatic model_byte(input logic [7:0] b);
        logic [7:0] txt[$];
        txt.push_back(hex_digits.getc(int'(b[7:4])));
        txt.push_back(hex_digits.getc(int'(b[3:0])));
`ifdef UART_HEX_TX_CRLF_EN
        txt.push_back(8'h0D);
        txt.push_back(8'h0A);
`endif
        foreach (txt[t]) begin
            logic [7:0] c;
            c = txt[t];
            exp_chars.push_back(c);
            for (int s = 0; s < 10; s++)
                for (int k = 0; k < BIT_CYC; k++)
                    exp_line.push_back((s == 0) ? 1'b0 : (s == 9) ? 1'b1 : c[s-1]);
        end
    endtask

    task automatic clear_all();
        exp_chars.delete();
        exp_line.delete();
        got_line.delete();
        got_ready.delete();
        got_busy.delete();
    endtask

    task automatic capture(input int n);
        repeat (n) begin
            @(negedge sys_clk);
            got_line.push_back(uart_txd);
            got_ready.push_back(bif.byte_ready);
            got_busy.push_back(tx_busy);
        end
    endtask

    // Waits (bounded) until the DUT will accept at the next posedge, then
    // returns just after that accept edge.
    task automatic wait_accept(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < LIMIT; i++) begin
            if (bif.byte_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge sys_clk);
        end
        @(posedge sys_clk);
    endtask

    function automatic int frame_errs(input int ch);
        int n;
        n = 0;
        for (int i = ch * FRAME_CYC; i < (ch + 1) * FRAME_CYC; i++)
            if (got_line[i] !== exp_line[i]) n++;
        return n;
    endfunction

    function automatic logic [7:0] decode_char(input int ch);
        logic [7:0] c;
        for (int i = 0; i < 8; i++)
            c[i] = got_line[ch * FRAME_CYC + (i + 1) * BIT_CYC + BIT_CYC / 2];
        return c;
    endfunction

    function automatic int first_ready();
        foreach (got_ready[i])
            if (got_ready[i] === 1'b1) return i + 1;
        return -1;
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        sys_rst = 1'b1;
        repeat (3) @(negedge sys_clk);
        n_checks++;
        if (uart_txd !== 1'b1) $display("FAIL reset_txd: got %b want 1", uart_txd);
        else n_pass++;
        n_checks++;
        if (bif.byte_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", bif.byte_ready);
        else n_pass++;
        n_checks++;
        if (tx_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", tx_busy);
        else n_pass++;
        sys_rst = 1'b0;
    endtask

    task automatic test_idle();
        int bad_txd, bad_busy;
        clear_all();
        capture(1000);
        bad_txd = 0;
        bad_busy = 0;
        foreach (got_line[i]) begin
            if (got_line[i] !== 1'b1) bad_txd++;
            if (got_busy[i] !== 1'b0) bad_busy++;
        end
        n_checks++;
        if (bad_txd != 0) $display("FAIL idle_txd: %0d cycles not high, want 0", bad_txd);
        else n_pass++;
        n_checks++;
        if (bad_busy != 0) $display("FAIL idle_busy: %0d cycles busy, want 0", bad_busy);
        else n_pass++;
    endtask

    // Sends one byte and checks frames, ready return and busy start.
    task automatic test_byte(input logic [7:0] b, input string tag);
        bit ok;
        clear_all();
        model_byte(b);
        bif.byte_data  = b;
        bif.byte_valid = 1'b1;
        wait_accept(ok);
        #1 bif.byte_valid = 1'b0;
        n_checks++;
        if (!ok) begin
            $display("FAIL %s_accept: timeout after %0d cycles", tag, LIMIT);
            return;
        end
        n_pass++;
        capture(BYTE_CYC + 20);
        for (int ch = 0; ch < CHARS; ch++) begin
            n_checks++;
            if (frame_errs(ch) !== 0)
                $display("FAIL %s_char%0d: got 0x%02h (%0d bad cycles) want 0x%02h",
                         tag, ch, decode_char(ch), frame_errs(ch), exp_chars[ch]);
            else n_pass++;
        end
        n_checks++;
        if (first_ready() != BYTE_CYC)
            $display("FAIL %s_ready_return: cycle %0d want %0d", tag, first_ready(), BYTE_CYC);
        else n_pass++;
        n_checks++;
        if (got_busy[0] !== 1'b1 || got_busy[BYTE_CYC-1] !== 1'b0)
            $display("FAIL %s_busy: first %b at_end %b want 1 0",
                     tag, got_busy[0], got_busy[BYTE_CYC-1]);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        bit ok;
        bit acc2;
        int acc2_at;
        clear_all();
        model_byte(8'h00);
        model_byte(8'hFF);
        bif.byte_data  = 8'h00;
        bif.byte_valid = 1'b1;
        wait_accept(ok);
        n_checks++;
        if (!ok) begin
            $display("FAIL b2b_accept1: timeout after %0d cycles", LIMIT);
            bif.byte_valid = 1'b0;
            return;
        end
        n_pass++;
        acc2 = 1'b0;
        acc2_at = -1;
        for (int j = 1; j <= 2 * BYTE_CYC; j++) begin
            @(negedge sys_clk);
            got_line.push_back(uart_txd);
            if (j == 1) bif.byte_data = 8'hFF;
            if (acc2 && j == acc2_at + 1) bif.byte_valid = 1'b0;
            if (!acc2 && bif.byte_valid && bif.byte_ready) begin
                acc2 = 1'b1;
                acc2_at = j;
            end
        end
        bif.byte_valid = 1'b0;
        n_checks++;
        if (acc2_at != BYTE_CYC)
            $display("FAIL b2b_spacing: second accept after %0d cycles want %0d", acc2_at, BYTE_CYC);
        else n_pass++;
        for (int ch = 0; ch < 2 * CHARS; ch++) begin
            n_checks++;
            if (frame_errs(ch) !== 0)
                $display("FAIL b2b_char%0d: got 0x%02h (%0d bad cycles) want 0x%02h",
                         ch, decode_char(ch), frame_errs(ch), exp_chars[ch]);
            else n_pass++;
        end
        repeat (20) @(negedge sys_clk);
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            logic [7:0] b;
            b = 8'($urandom_range(0, 255));
            repeat ($urandom_range(0, 20)) @(negedge sys_clk);
            test_byte(b, $sformatf("rand%0d", r));
        end
    endtask

    task automatic test_ignore_busy();
        bit ok;
        int bad;
        logic [7:0] b;
        b = 8'($urandom_range(0, 255));
        if (b == 8'h12) b = 8'h5A;
        clear_all();
        model_byte(b);
        bif.byte_data  = b;
        bif.byte_valid = 1'b1;
        wait_accept(ok);
        #1 bif.byte_valid = 1'b0;
        n_checks++;
        if (!ok) begin
            $display("FAIL ignore_accept: timeout after %0d cycles", LIMIT);
            return;
        end
        n_pass++;
        capture(50);
        bif.byte_data  = 8'h12;
        bif.byte_valid = 1'b1;
        capture(1);
        bif.byte_valid = 1'b0;
        capture(BYTE_CYC - 51 + 60);
        for (int ch = 0; ch < CHARS; ch++) begin
            n_checks++;
            if (frame_errs(ch) !== 0)
                $display("FAIL ignore_char%0d: got 0x%02h want 0x%02h",
                         ch, decode_char(ch), exp_chars[ch]);
            else n_pass++;
        end
        bad = 0;
        for (int i = BYTE_CYC; i < BYTE_CYC + 60; i++)
            if (got_line[i] !== 1'b1 || got_busy[i] !== 1'b0) bad++;
        n_checks++;
        if (bad != 0) $display("FAIL ignore_after: %0d non-idle cycles want 0", bad);
        else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        int bad;
        clear_all();
        model_byte(8'hA5);
        bif.byte_data  = 8'hA5;
        bif.byte_valid = 1'b1;
        wait_accept(ok);
        #1 bif.byte_valid = 1'b0;
        n_checks++;
        if (!ok) begin
            $display("FAIL rstmid_accept: timeout after %0d cycles", LIMIT);
            return;
        end
        n_pass++;
        capture(56);
        bad = 0;
        for (int i = 0; i < 56; i++)
            if (got_line[i] !== exp_line[i]) bad++;
        n_checks++;
        if (bad != 0) $display("FAIL rstmid_prefix: %0d bad cycles want 0", bad);
        else n_pass++;
        sys_rst = 1'b1;
        @(negedge sys_clk);
        n_checks++;
        if (uart_txd !== 1'b1 || bif.byte_ready !== 1'b1 || tx_busy !== 1'b0)
            $display("FAIL rstmid_state: txd %b ready %b busy %b want 1 1 0",
                     uart_txd, bif.byte_ready, tx_busy);
        else n_pass++;
        sys_rst = 1'b0;
        clear_all();
        capture(300);
        bad = 0;
        foreach (got_line[i])
            if (got_line[i] !== 1'b1 || got_busy[i] !== 1'b0) bad++;
        n_checks++;
        if (bad != 0) $display("FAIL rstmid_no_resume: %0d non-idle cycles want 0", bad);
        else n_pass++;
    endtask

    initial begin
        bif.byte_valid = 1'b0;
        bif.byte_data  = 8'h00;
        test_reset();
        test_idle();
        test_byte(8'h3C, "hex3c");
`ifdef UART_HEX_TX_CRLF_EN
        test_byte(8'h7E, "crlf7e");
`endif
        test_back_to_back();
        test_random();
        test_ignore_busy();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
